// File: rtl/saa_cfg_sequencer.sv
// saa_cfg_sequencer: power-up register loader for the SAA7111 video decoder.
//
// Walks an external (sub-address, data) table and issues one I2C byte-write per
// entry to the shared I2C byte master. Failed writes are retried. The block then
// reports done or error on the board LEDs.
//
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   start                one-cycle pulse, re-runs the sequence from DONE/ERROR
//   tbl_idx/sub/dat      table ROM index out, combinational entry contents in
//   i2c_req/dev/sub/wdat transaction request and payload to the I2C master
//   i2c_ack/nack         one-cycle completion pulses from the I2C master
//   busy, init_done      sequence in progress / all entries written
//   init_err, err_idx    an entry exhausted its retries, and which one
//   led                  {init_err, init_done}
//
// Optional build macro SAA_LOCK_POLL_EN adds i2c_rd/i2c_rdat. With it, the block
// polls the HLCK status bit (sub-address 0x1F, bit 6) after the last write and
// reports done only once the decoder reports horizontal lock.

module saa_cfg_sequencer #(
  parameter logic [6:0]  DEV_ADDR   = 7'h24,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned PWRUP_WAIT = 50000,
  parameter int unsigned GAP_CYC    = 64,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned TIMEOUT    = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] tbl_idx,
  input  logic [7:0] tbl_sub,
  input  logic [7:0] tbl_dat,
  output logic       i2c_req,
  output logic [6:0] i2c_dev,
  output logic [7:0] i2c_sub,
  output logic [7:0] i2c_wdat,
  input  logic       i2c_ack,
  input  logic       i2c_nack,
`ifdef SAA_LOCK_POLL_EN
  output logic       i2c_rd,
  input  logic [7:0] i2c_rdat,
`endif
  output logic       busy,
  output logic       init_done,
  output logic       init_err,
  output logic [7:0] err_idx,
  output logic [1:0] led
);

  localparam int unsigned CntTop0 = (PWRUP_WAIT > TIMEOUT) ? PWRUP_WAIT : TIMEOUT;
  localparam int unsigned CntTop  = (CntTop0 > GAP_CYC) ? CntTop0 : GAP_CYC;
  localparam int unsigned CntW    = $clog2(CntTop + 1);
  localparam logic [7:0]  LastIdx = 8'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    StPwrup, StFetch, StIssue, StWait, StGap, StPoll, StDone, StError
  } state_e;

  state_e            state_q, state_d;
  state_e            nxt_q, nxt_d;     // where GAP goes once it expires
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [7:0]        idx_q, idx_d;
  logic [3:0]        retry_q, retry_d;
  logic [7:0]        sub_q, sub_d;
  logic [7:0]        wdat_q, wdat_d;
  logic [7:0]        err_q, err_d;
  logic              rd_q, rd_d;
  logic [7:0]        poll_q, poll_d;
  logic              hlck;
  logic              fail;

`ifdef SAA_LOCK_POLL_EN
  localparam bit PollEn = 1'b1;
  assign hlck   = i2c_rdat[6];
  assign i2c_rd = rd_q;
`else
  localparam bit PollEn = 1'b0;
  assign hlck = 1'b0;
`endif

  // Any completion other than a clean ack, or the request window expiring,
  // counts as a failed attempt.
  assign fail = i2c_nack || (cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    nxt_d   = nxt_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    retry_d = retry_q;
    sub_d   = sub_q;
    wdat_d  = wdat_q;
    err_d   = err_q;
    rd_d    = rd_q;
    poll_d  = poll_q;

    unique case (state_q)
      StPwrup: if (cnt_q == CntW'(PWRUP_WAIT - 1)) state_d = StFetch;
      StFetch: begin
        sub_d   = tbl_sub;
        wdat_d  = tbl_dat;
        rd_d    = 1'b0;
        retry_d = '0;
        state_d = StIssue;
      end
      StPoll: begin
        sub_d   = 8'h1F;
        wdat_d  = 8'h00;
        rd_d    = 1'b1;
        retry_d = '0;
        state_d = StIssue;
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (i2c_ack && !i2c_nack) begin
          if (rd_q) begin
            if (!hlck) begin
              state_d = StDone;
            end else if (poll_q == 8'd254) begin
              err_d   = 8'hFF;
              state_d = StError;
            end else begin
              poll_d  = poll_q + 8'd1;
              nxt_d   = StPoll;
              state_d = StGap;
            end
          end else if (idx_q == LastIdx) begin
            poll_d  = '0;
            state_d = PollEn ? StPoll : StDone;
          end else begin
            idx_d   = idx_q + 8'd1;
            nxt_d   = StFetch;
            state_d = StGap;
          end
        end else if (fail) begin
          retry_d = retry_q + 4'd1;
          if (retry_d == 4'(MAX_RETRY)) begin
            err_d   = idx_q;
            state_d = StError;
          end else begin
            nxt_d   = StIssue;
            state_d = StGap;
          end
        end
      end
      StGap: if (cnt_q == CntW'(GAP_CYC - 1)) state_d = nxt_q;
      StDone, StError: begin
        if (start) begin
          idx_d   = '0;
          err_d   = '0;
          poll_d  = '0;
          state_d = StPwrup;
        end
      end
    endcase

    // The counter restarts on each state change, except ISSUE->WAIT, so the
    // timeout window covers every cycle i2c_req is high.
    if (state_d != state_q && state_q != StIssue) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StPwrup;
      nxt_q   <= StFetch;
      cnt_q   <= '0;
      idx_q   <= '0;
      retry_q <= '0;
      sub_q   <= '0;
      wdat_q  <= '0;
      err_q   <= '0;
      rd_q    <= 1'b0;
      poll_q  <= '0;
    end else begin
      state_q <= state_d;
      nxt_q   <= nxt_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      sub_q   <= sub_d;
      wdat_q  <= wdat_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      poll_q  <= poll_d;
    end
  end

  assign tbl_idx   = idx_q;
  assign i2c_req   = (state_q == StIssue) || (state_q == StWait);
  assign i2c_dev   = DEV_ADDR;
  assign i2c_sub   = sub_q;
  assign i2c_wdat  = wdat_q;
  assign init_done = (state_q == StDone);
  assign init_err  = (state_q == StError);
  assign busy      = !(init_done || init_err);
  assign err_idx   = err_q;
  assign led       = {init_err, init_done};

endmodule

// File: tb/tb_saa_cfg_sequencer.sv
// Self-checking bench for saa_cfg_sequencer: scripted I2C master responses
// against a transaction-level timing model of the configuration sequence.

module tb_saa_cfg_sequencer;

  localparam int NREG = 4;
  localparam int PW   = 8;
  localparam int GAP  = 2;
  localparam int MR   = 2;
  localparam int TO   = 20;

  localparam int KAck  = 0;
  localparam int KNack = 1;
  localparam int KBoth = 2;
  localparam int KNone = 3;

  logic       clk, rst, start;
  logic [7:0] tbl_idx, tbl_sub, tbl_dat;
  logic       i2c_req, i2c_ack, i2c_nack;
  logic [6:0] i2c_dev;
  logic [7:0] i2c_sub, i2c_wdat, err_idx;
  logic       busy, init_done, init_err;
  logic [1:0] led;

  logic [7:0] rom_sub [NREG];
  logic [7:0] rom_dat [NREG];

  // Master script and observed transactions, indexed by request number.
  int         kind  [64];
  int         lat   [64];
  int         r_t   [64];
  int         r_dur [64];
  logic [7:0] r_sub [64];
  logic [7:0] r_dat [64];
  int         nreq;
  int         unstable;

  // Expected transactions.
  int         e_t   [64];
  int         e_dur [64];
  logic [7:0] e_sub [64];
  logic [7:0] e_dat [64];
  int         n_exp;
  bit         e_done, e_err;
  logic [7:0] e_eidx;

  int cyc;
  int vectors;
  int miscompares;

  saa_cfg_sequencer #(
    .DEV_ADDR  (7'h24),
    .NUM_REGS  (NREG),
    .PWRUP_WAIT(PW),
    .GAP_CYC   (GAP),
    .MAX_RETRY (MR),
    .TIMEOUT   (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .tbl_idx  (tbl_idx),
    .tbl_sub  (tbl_sub),
    .tbl_dat  (tbl_dat),
    .i2c_req  (i2c_req),
    .i2c_dev  (i2c_dev),
    .i2c_sub  (i2c_sub),
    .i2c_wdat (i2c_wdat),
    .i2c_ack  (i2c_ack),
    .i2c_nack (i2c_nack),
    .busy     (busy),
    .init_done(init_done),
    .init_err (init_err),
    .err_idx  (err_idx),
    .led      (led)
  );

  assign tbl_sub = (tbl_idx < 8'(NREG)) ? rom_sub[tbl_idx[1:0]] : 8'h00;
  assign tbl_dat = (tbl_idx < 8'(NREG)) ? rom_dat[tbl_idx[1:0]] : 8'h00;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle n = state visible after the n-th rising edge following reset.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // I2C master model: responds to request k per kind[k] after lat[k] cycles.
  initial begin : master
    int   w;
    int   cur;
    logic prev;
    w = 0; cur = 0; prev = 1'b0; nreq = 0; unstable = 0;
    i2c_ack = 1'b0; i2c_nack = 1'b0;
    forever begin
      @(negedge clk);
      i2c_ack  = 1'b0;
      i2c_nack = 1'b0;
      if (rst) begin
        nreq = 0; w = 0; prev = 1'b0;
      end else begin
        if (i2c_req && !prev) begin
          cur = nreq;
          nreq++;
          r_t[cur]   = cyc;
          r_sub[cur] = i2c_sub;
          r_dat[cur] = i2c_wdat;
          r_dur[cur] = 1;
          w = (kind[cur] == KNone) ? 0 : lat[cur] - 1;
        end else if (i2c_req) begin
          r_dur[cur]++;
          if (i2c_sub !== r_sub[cur] || i2c_wdat !== r_dat[cur]) unstable++;
          if (w > 0) begin
            w--;
            if (w == 0) begin
              i2c_ack  = (kind[cur] != KNack);
              i2c_nack = (kind[cur] != KAck);
            end
          end
        end
        prev = i2c_req;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected transaction list from the sequencing rules: first request
  // PW+1 cycles after the run starts, retries GAP idle cycles later, next
  // entry GAP+1 idle cycles later (gap plus fetch).
  task automatic model(input int t0, input int k0);
    int t, idx, retry, k, l;
    bit fin;
    t = t0; idx = 0; retry = 0; k = 0; fin = 1'b0;
    e_done = 1'b0; e_err = 1'b0; e_eidx = 8'h00;
    while (!fin) begin
      l = (kind[k0+k] == KNone) ? TO : lat[k0+k];
      e_t[k0+k]   = t;
      e_dur[k0+k] = l;
      e_sub[k0+k] = rom_sub[idx];
      e_dat[k0+k] = rom_dat[idx];
      if (kind[k0+k] == KAck) begin
        if (idx == NREG - 1) begin
          fin = 1'b1; e_done = 1'b1;
        end else begin
          idx++; retry = 0; t = t + l + GAP + 1;
        end
      end else begin
        retry++;
        if (retry == MR) begin
          fin = 1'b1; e_err = 1'b1; e_eidx = 8'(idx);
        end else begin
          t = t + l + GAP;
        end
      end
      k++;
    end
    n_exp = k;
  endtask

  task automatic fill_table();
    for (int i = 0; i < NREG; i++) begin
      rom_sub[i] = 8'($urandom);
      rom_dat[i] = 8'($urandom);
    end
  endtask

  task automatic script_ack(input int l);
    for (int k = 0; k < 64; k++) begin
      kind[k] = KAck;
      lat[k]  = (l == 0) ? int'($urandom_range(2, 8)) : l;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst req", i2c_req, 0);
    chk("rst idx", tbl_idx, 0);
    chk("rst busy", busy, 1);
    chk("rst done/err", {init_done, init_err}, 0);
    chk("rst err_idx", err_idx, 0);
    chk("rst led", led, 0);
    chk("rst sub/wdat", {i2c_sub, i2c_wdat}, 0);
    chk("rst dev", i2c_dev, 7'h24);
    rst = 1'b0;
  endtask

  task automatic wait_req(input int n);
    int b;
    b = 0;
    while (nreq < n && b < 2000) begin
      @(negedge clk);
      b++;
    end
    chk("wait req", nreq >= n, 1);
  endtask

  task automatic check_run(input string tag, input int k0);
    int b;
    b = 0;
    while (busy && b < 3000) begin
      @(negedge clk);
      b++;
    end
    repeat (3) @(negedge clk);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " nreq"}, nreq - k0, n_exp);
    for (int i = k0; i < k0 + n_exp; i++) begin
      chk($sformatf("%s req%0d cycle", tag, i), r_t[i], e_t[i]);
      chk($sformatf("%s req%0d sub", tag, i), r_sub[i], e_sub[i]);
      chk($sformatf("%s req%0d dat", tag, i), r_dat[i], e_dat[i]);
      chk($sformatf("%s req%0d len", tag, i), r_dur[i], e_dur[i]);
    end
    chk({tag, " done"}, init_done, e_done);
    chk({tag, " err"}, init_err, e_err);
    chk({tag, " err_idx"}, err_idx, e_eidx);
    chk({tag, " led"}, led, {e_err, e_done});
    chk({tag, " req idle"}, i2c_req, 0);
    chk({tag, " stable"}, unstable, 0);
  endtask

  initial begin : main
    int k0, s;
    vectors = 0; miscompares = 0;
    rst = 1'b1; start = 1'b0;

    // All entries acked.
    fill_table(); script_ack(5);
    do_reset(); model(PW + 1, 0); check_run("ack", 0);

    // Entry 2 NACKed once.
    fill_table(); script_ack(0); kind[2] = KNack;
    do_reset(); model(PW + 1, 0); check_run("nack1", 0);

    // Entry 1 NACKed twice, then restart with start.
    fill_table(); script_ack(0); kind[1] = KNack; kind[2] = KNack;
    do_reset(); model(PW + 1, 0); check_run("err", 0);
    k0 = nreq;
    @(negedge clk);
    start = 1'b1; s = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    chk("restart busy", busy, 1);
    model(s + PW + 1, k0); check_run("rerun", k0);

    // Master never answers.
    fill_table();
    for (int k = 0; k < 64; k++) begin kind[k] = KNone; lat[k] = 2; end
    do_reset(); model(PW + 1, 0); check_run("timeout", 0);

    // Reset while waiting on entry 2.
    fill_table(); script_ack(5);
    do_reset(); wait_req(3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst req", i2c_req, 0);
    chk("midrst idx", tbl_idx, 0);
    chk("midrst busy", busy, 1);
    @(negedge clk);
    rst = 1'b0;
    model(PW + 1, 0); check_run("replay", 0);

    // start ignored mid-sequence; ack+nack together counts as a retry.
    fill_table(); script_ack(0); kind[1] = KBoth;
    do_reset(); wait_req(2);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("start ignored idx", tbl_idx, 1);
    chk("start ignored busy", busy, 1);
    model(PW + 1, 0); check_run("both", 0);

    // Randomized response scripts.
    for (int r = 0; r < 5; r++) begin
      fill_table();
      for (int k = 0; k < 64; k++) begin
        case ($urandom_range(0, 9))
          0:       kind[k] = KNack;
          1:       kind[k] = KBoth;
          2:       kind[k] = KNone;
          default: kind[k] = KAck;
        endcase
        lat[k] = int'($urandom_range(2, 8));
      end
      do_reset(); model(PW + 1, 0); check_run($sformatf("rand%0d", r), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
